pc_flow_ctrl: RTL

Control-flow sequencer for the single-cycle core's PC circuit. Each cycle it turns the decoded control-flow op and the condition flags into the PC-select strobes (BRANCH, JMP, flag_Rd_PC, flag_label_PC, flag_Rm_PC) and a PC update enable. It owns a small return-address stack (RAS) for CALL/RET, and a state machine for post-reset hold, stall and halt.

---
 rtl/pc_flow_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: PC-select strobes, return-address stack and HOLD/RUN/STALL/HALT sequencing.
// Optional macro PC_FLOW_PERF_EN adds the saturating perf_taken counter.
`timescale 1ns/1ps
module pc_flow_ctrl #(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            op_valid,
  input  logic [2:0]      op_type,
  input  logic [3:0]      cond,
  input  logic [3:0]      nzcv,
  input  logic [PC_W-1:0] pc,
  input  logic            stall,
  input  logic            resume,
  output logic            pc_en,
  output logic            BRANCH,
  output logic            JMP,
  output logic            flag_Rd_PC,
  output logic            flag_label_PC,
  output logic            flag_Rm_PC,
  output logic            ras_sel,
  output logic [PC_W-1:0] ras_top,
  output logic            ras_err,
  output logic [1:0]      state
`ifdef PC_FLOW_PERF_EN
  ,
  output logic [15:0]     perf_taken
`endif
);

  localparam int IDX_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int PTR_W  = IDX_W + 1;
  localparam int HCNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYC - 1);
  localparam logic [PTR_W-1:0]  PTR_FULL  = PTR_W'(RAS_DEPTH);

  localparam logic [2:0] OP_SEQ    = 3'd0;
  localparam logic [2:0] OP_BCOND  = 3'd1;
  localparam logic [2:0] OP_JRD    = 3'd2;
  localparam logic [2:0] OP_JLABEL = 3'd3;
  localparam logic [2:0] OP_JRM    = 3'd4;
  localparam logic [2:0] OP_CALL   = 3'd5;
  localparam logic [2:0] OP_RET    = 3'd6;
  localparam logic [2:0] OP_HALT   = 3'd7;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t              r_state;
  logic [HCNT_W-1:0]   r_hold_cnt;
  logic [PC_W-1:0]     r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]    r_ptr;
  logic                r_err;

  logic                w_n, w_z, w_c, w_v;
  logic                w_cond_pass;
  logic                w_active;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_fault;
  logic                w_halt_op;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [IDX_W-1:0]    w_top_idx;
  logic [PC_W-1:0]     w_ret_addr;

  assign {w_n, w_z, w_c, w_v} = nzcv;

  always_comb begin
    w_cond_pass = 1'b0;
    case (cond)
      4'd0:    w_cond_pass = w_z;
      4'd1:    w_cond_pass = !w_z;
      4'd2:    w_cond_pass = w_c;
      4'd3:    w_cond_pass = !w_c;
      4'd4:    w_cond_pass = w_n;
      4'd5:    w_cond_pass = !w_n;
      4'd6:    w_cond_pass = w_v;
      4'd7:    w_cond_pass = !w_v;
      4'd8:    w_cond_pass = w_c && !w_z;
      4'd9:    w_cond_pass = !w_c || w_z;
      4'd10:   w_cond_pass = (w_n == w_v);
      4'd11:   w_cond_pass = (w_n != w_v);
      4'd12:   w_cond_pass = !w_z && (w_n == w_v);
      4'd13:   w_cond_pass = w_z || (w_n != w_v);
      4'd14:   w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end

  // stall overrides everything combinationally while in RUN
  assign w_active   = (r_state == ST_RUN) && !stall;
  assign w_empty    = (r_ptr == '0);
  assign w_full     = (r_ptr == PTR_FULL);
  assign w_wr_idx   = r_ptr[IDX_W-1:0];
  assign w_top_idx  = r_ptr[IDX_W-1:0] - IDX_W'(1);
  assign w_ret_addr = pc + PC_W'(1);

  always_comb begin
    pc_en         = w_active;
    BRANCH        = 1'b0;
    JMP           = 1'b0;
    flag_Rd_PC    = 1'b0;
    flag_label_PC = 1'b0;
    flag_Rm_PC    = 1'b0;
    ras_sel       = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_fault       = 1'b0;
    w_halt_op     = 1'b0;
    if (w_active && op_valid) begin
      case (op_type)
        OP_SEQ: ;
        OP_BCOND:  BRANCH = w_cond_pass;
        OP_JRD: begin
          JMP        = 1'b1;
          flag_Rd_PC = 1'b1;
        end
        OP_JLABEL: begin
          JMP           = 1'b1;
          flag_label_PC = 1'b1;
        end
        OP_JRM: begin
          JMP        = 1'b1;
          flag_Rm_PC = 1'b1;
        end
        OP_CALL: begin
          // jump is taken even when the return address cannot be saved
          JMP           = 1'b1;
          flag_label_PC = 1'b1;
          w_push        = !w_full;
          w_fault       = w_full;
        end
        OP_RET: begin
          if (w_empty) begin
            w_fault = 1'b1;
          end else begin
            JMP        = 1'b1;
            flag_Rm_PC = 1'b1;
            ras_sel    = 1'b1;
            w_pop      = 1'b1;
          end
        end
        OP_HALT: begin
          pc_en     = 1'b0;
          w_halt_op = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= ST_RUN;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HCNT_W'(1);
          end
        end
        ST_RUN: begin
          if (stall)          r_state <= ST_STALL;
          else if (w_halt_op) r_state <= ST_HALT;
        end
        ST_STALL: if (!stall) r_state <= ST_RUN;
        ST_HALT:  if (resume) r_state <= ST_RUN;
        default:  r_state <= ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ptr <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else begin
      if (w_push) begin
        r_ras[w_wr_idx] <= w_ret_addr;
        r_ptr           <= r_ptr + PTR_W'(1);
      end else if (w_pop) begin
        r_ptr <= r_ptr - PTR_W'(1);
      end
      if (w_fault) r_err <= 1'b1;
    end
  end

  assign ras_top = w_empty ? '0 : r_ras[w_top_idx];
  assign ras_err = r_err;
  assign state   = r_state;

`ifdef PC_FLOW_PERF_EN
  logic [15:0] r_perf;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_perf <= '0;
    end else if (pc_en && (BRANCH || JMP) && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign perf_taken = r_perf;
`endif

endmodule
